// File: rtl/ysyx_23060061_csr_file.sv
// ysyx_23060061_csr_file: machine-mode CSR file (mstatus, mscratch,
// mtvec, mepc, mcause, mvendorid) with ecall/mret trap sequencing.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   csr_en/op/addr  - CSR access request (op: 00 rd, 01 RW, 10 RS, 11 RC)
//   csr_wdata       - write data / bit mask
//   csr_rdata       - pre-update value of the addressed CSR
//   csr_illegal     - unimplemented address or write to read-only CSR
//   ecall, mret, pc - trap entry / return and trapping PC
//   mtvec, mepc     - registered trap vector and return address
//   mie_out         - registered mstatus.MIE
//
// Optional feature: define YSYX_23060061_CSR_MCYCLE_EN to add a 64-bit
// cycle counter at 0xB00 (mcycle) and 0xB80 (mcycleh, XLEN=32 only).
module ysyx_23060061_csr_file #(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            ecall,
    input  logic            mret,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            mie_out
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MVENDOR  = 12'hF11;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam bit          HAS_HI     = (XLEN == 32);
`endif

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
    logic [63:0]     cyc_q, cyc_d;
`endif

    logic            impl;
    logic            wr_en;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] mstatus_val;
    logic            unused_pc0;

    assign unused_pc0 = pc[0];

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie_q;
        mstatus_val[3]     = mie_q;
    end

    // Address decode and pre-update read value
    always_comb begin
        impl   = 1'b1;
        rd_val = '0;
        case (csr_addr)
            A_MSTATUS:  rd_val = mstatus_val;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MVENDOR:  rd_val = '0;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
            A_MCYCLE:   rd_val = XLEN'(cyc_q);
            A_MCYCLEH: begin
                impl = HAS_HI;
                if (HAS_HI) rd_val = XLEN'(cyc_q[63:32]);
            end
`endif
            default:    impl = 1'b0;
        endcase
    end

    assign csr_rdata   = rd_val;
    assign csr_illegal = csr_en &&
        (!impl || (csr_addr == A_MVENDOR && csr_op != 2'b00));

    // CSR write only lands when no trap event claims the cycle
    assign wr_en = csr_en && (csr_op != 2'b00) && !csr_illegal &&
                   !ecall && !mret;

    always_comb begin
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = rd_val | csr_wdata;
            2'b11:   new_val = rd_val & ~csr_wdata;
            default: new_val = rd_val;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mscratch_d = mscratch_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
        cyc_d      = cyc_q + 64'd1;
`endif
        if (ecall) begin
            mepc_d   = {pc[XLEN-1:1], 1'b0};
            mcause_d = XLEN'(ECALL_CAUSE);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                A_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d     = {new_val[XLEN-1:1], 1'b0};
                A_MCAUSE:   mcause_d   = new_val;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
                // A written half replaces this cycle's increment
                A_MCYCLE: begin
                    if (HAS_HI)
                        cyc_d = {cyc_q[63:32], new_val[31:0]};
                    else
                        cyc_d = 64'(new_val);
                end
                A_MCYCLEH:
                    cyc_d = {new_val[31:0], cyc_q[31:0]};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mscratch_q <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
            cyc_q      <= '0;
`endif
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mscratch_q <= mscratch_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
`ifdef YSYX_23060061_CSR_MCYCLE_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    assign mtvec   = mtvec_q;
    assign mepc    = mepc_q;
    assign mie_out = mie_q;

endmodule

// File: tb/tb_ysyx_23060061_csr_file.sv
// tb_ysyx_23060061_csr_file: directed stimulus with a CSR-level
// reference model compared every cycle, plus literal spot checks.
module tb_ysyx_23060061_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_en = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        ecall = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie_out;

`ifdef YSYX_23060061_CSR_MCYCLE_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    ysyx_23060061_csr_file #(.XLEN(32), .ECALL_CAUSE(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_en     (csr_en),
        .csr_op     (csr_op),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_illegal(csr_illegal),
        .ecall      (ecall),
        .mret       (mret),
        .pc         (pc),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mie_out    (mie_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural CSR state
    bit        m_valid = 1'b0;
    bit        m_mie, m_mpie;
    bit [31:0] m_scr, m_tvec, m_epc, m_cause;
    bit [63:0] m_cyc;

    function automatic bit m_impl(input bit [11:0] a);
        if (a inside {12'h300, 12'h305, 12'h340,
                      12'h341, 12'h342, 12'hF11})
            return 1'b1;
        return MC && (a inside {12'hB00, 12'hB80});
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7)
                            | (32'(m_mie) << 3);
            12'h305: return m_tvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'hB00: return MC ? m_cyc[31:0] : 32'h0;
            12'hB80: return MC ? m_cyc[63:32] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_ill(input bit en, input bit [1:0] op,
                                 input bit [11:0] a);
        return en && (!m_impl(a) || (a == 12'hF11 && op != 2'b00));
    endfunction

    always @(posedge clk) begin
        bit [31:0] o, n;
        bit [63:0] cn;
        if (rst) begin
            m_valid = 1'b1;
            m_mie = 0; m_mpie = 0;
            m_scr = 0; m_tvec = 0; m_epc = 0; m_cause = 0;
            m_cyc = 0;
        end else if (m_valid) begin
            cn = m_cyc + 64'd1;
            if (ecall) begin
                m_epc   = pc & ~32'h1;
                m_cause = 32'd11;
                m_mpie  = m_mie;
                m_mie   = 1'b0;
            end else if (mret) begin
                m_mie  = m_mpie;
                m_mpie = 1'b1;
            end else if (csr_en && csr_op != 2'b00 &&
                         !m_ill(csr_en, csr_op, csr_addr)) begin
                o = m_read(csr_addr);
                n = (csr_op == 2'b01) ? csr_wdata :
                    (csr_op == 2'b10) ? (o | csr_wdata) :
                                        (o & ~csr_wdata);
                case (csr_addr)
                    12'h300: begin m_mie = n[3]; m_mpie = n[7]; end
                    12'h305: m_tvec = n & ~32'h3;
                    12'h340: m_scr  = n;
                    12'h341: m_epc  = n & ~32'h1;
                    12'h342: m_cause = n;
                    12'hB00: cn = {m_cyc[63:32], n};
                    12'hB80: cn = {n, m_cyc[31:0]};
                    default: ;
                endcase
            end
            m_cyc = cn;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_rdata", 64'(csr_rdata), 64'(m_read(csr_addr)));
            chk("cmp_illegal", 64'(csr_illegal),
                64'(m_ill(csr_en, csr_op, csr_addr)));
            chk("cmp_mtvec", 64'(mtvec), 64'(m_tvec));
            chk("cmp_mepc", 64'(mepc), 64'(m_epc));
            chk("cmp_mie", 64'(mie_out), 64'(m_mie));
        end
    end

    task automatic step(input bit r, input bit en, input bit [1:0] op,
                        input bit [11:0] a, input bit [31:0] wd,
                        input bit ec, input bit mr, input bit [31:0] p);
        @(posedge clk);
        #1;
        rst = r; csr_en = en; csr_op = op; csr_addr = a;
        csr_wdata = wd; ecall = ec; mret = mr; pc = p;
        @(negedge clk);
    endtask

    task automatic rd(input bit [11:0] a);
        step(0, 1, 2'b00, a, 0, 0, 0, 0);
    endtask

    task automatic wr(input bit [1:0] op, input bit [11:0] a,
                      input bit [31:0] wd);
        step(0, 1, op, a, wd, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        rd(12'h305);
        chk("rst_mtvec", 64'(mtvec), 64'h0);
        chk("rst_mepc", 64'(mepc), 64'h0);
        chk("rst_mie", 64'(mie_out), 64'h0);
        chk("rst_rd305", 64'(csr_rdata), 64'h0);
        rd(12'h300);
        chk("rst_mstatus", 64'(csr_rdata), 64'h1800);

        wr(2'b01, 12'h305, 32'h8000_0003);
        rd(12'h305);
        chk("mtvec_rd", 64'(csr_rdata), 64'h8000_0000);
        chk("mtvec_out", 64'(mtvec), 64'h8000_0000);

        wr(2'b10, 12'h300, 32'h8);
        rd(12'h300);
        chk("mie_set", 64'(mie_out), 64'h1);
        step(0, 0, 0, 0, 0, 1, 0, 32'h8000_0105);
        rd(12'h341);
        chk("ecall_mepc", 64'(mepc), 64'h8000_0104);
        chk("ecall_rdmepc", 64'(csr_rdata), 64'h8000_0104);
        rd(12'h342);
        chk("ecall_mcause", 64'(csr_rdata), 64'd11);
        rd(12'h300);
        chk("ecall_mstatus", 64'(csr_rdata), 64'h1880);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        rd(12'h300);
        chk("mret_mstatus", 64'(csr_rdata), 64'h1888);
        chk("mret_mie", 64'(mie_out), 64'h1);

        step(0, 1, 2'b01, 12'h340, 32'hDEAD, 1, 0, 32'h200);
        rd(12'h340);
        chk("prio_mscratch", 64'(csr_rdata), 64'h0);
        chk("prio_mepc", 64'(mepc), 64'h200);
        step(0, 0, 0, 0, 0, 1, 1, 32'h301);
        rd(12'h300);
        chk("ecall_mret", 64'(csr_rdata), 64'h1800);
        chk("ecall_mret_epc", 64'(mepc), 64'h300);

        wr(2'b01, 12'h7C0, 32'h5);
        chk("ill_7c0", 64'(csr_illegal), 64'h1);
        wr(2'b01, 12'hF11, 32'h1);
        chk("ill_f11w", 64'(csr_illegal), 64'h1);
        rd(12'hF11);
        chk("f11_rd_ill", 64'(csr_illegal), 64'h0);
        chk("f11_rd_val", 64'(csr_rdata), 64'h0);
        rd(12'h305);
        chk("ill_nochange", 64'(csr_rdata), 64'h8000_0000);

        wr(2'b01, 12'h340, 32'hFF00_FF00);
        wr(2'b11, 12'h340, 32'h0F00_0F00);
        wr(2'b10, 12'h340, 32'h0000_000F);
        wr(2'b00, 12'h340, 32'h1234);
        rd(12'h340);
        chk("rc_rs", 64'(csr_rdata), 64'hF000_F00F);
        wr(2'b01, 12'h341, 32'h13);
        rd(12'h341);
        chk("mepc_bit0", 64'(csr_rdata), 64'h12);

`ifdef YSYX_23060061_CSR_MCYCLE_EN
        wr(2'b01, 12'hB80, 32'h0);
        wr(2'b01, 12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00);
        chk("mcyc_wr", 64'(csr_rdata), 64'hFFFF_FFFE);
        rd(12'hB00);
        rd(12'hB00);
        chk("mcyc_wrap", 64'(csr_rdata), 64'h0);
        rd(12'hB80);
        chk("mcych_carry", 64'(csr_rdata), 64'h1);
`else
        rd(12'hB00);
        chk("no_mcyc", 64'(csr_illegal), 64'h1);
        rd(12'hB80);
        chk("no_mcych", 64'(csr_illegal), 64'h1);
`endif

        step(1, 1, 2'b01, 12'h340, 32'h55, 1, 0, 32'h400);
        rd(12'h340);
        chk("rst2_scr", 64'(csr_rdata), 64'h0);
        chk("rst2_mepc", 64'(mepc), 64'h0);
        chk("rst2_mtvec", 64'(mtvec), 64'h0);
        rd(12'h342);
        chk("rst2_mcause", 64'(csr_rdata), 64'h0);
        rd(12'h300);
        chk("rst2_mstatus", 64'(csr_rdata), 64'h1800);

        step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
